// File: rtl/kernel_bc_fifo_srl_param_if.sv
`default_nettype none
// ============================================================================
// Module   : kernel_bc_fifo_srl_param_if
// Brief    : Write/read handshake and status bundle of the parametrised SRL FIFO.
// Revision : 1.0 - initial release
// ============================================================================
interface kernel_bc_fifo_srl_param_if #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 5
);
    logic [DATA_WIDTH-1:0] if_din;
    logic                  if_write;
    logic                  if_write_ce;
    logic                  if_full_n;
    logic [DATA_WIDTH-1:0] if_dout;
    logic                  if_read;
    logic                  if_read_ce;
    logic                  if_empty_n;
    logic [ADDR_WIDTH:0]   if_count;
    logic                  if_almost_full_n;
    logic                  if_almost_empty_n;
    logic                  if_ovf;
    logic                  if_udf;

    modport master (
        output if_din, if_write, if_write_ce, if_read, if_read_ce,
        input  if_full_n, if_dout, if_empty_n, if_count,
               if_almost_full_n, if_almost_empty_n, if_ovf, if_udf
    );

    modport slave (
        input  if_din, if_write, if_write_ce, if_read, if_read_ce,
        output if_full_n, if_dout, if_empty_n, if_count,
               if_almost_full_n, if_almost_empty_n, if_ovf, if_udf
    );
endinterface
`default_nettype wire

// File: rtl/kernel_bc_fifo_srl_param.sv
`default_nettype none
// ============================================================================
// Module   : kernel_bc_fifo_srl_param
// Brief    : Shift-register FIFO with free width/depth, occupancy, threshold
//            flags, sticky over/underflow and optional registered head word.
// Revision : 1.0 - initial release
// ============================================================================
module kernel_bc_fifo_srl_param #(
    parameter int DATA_WIDTH    = 32,
    parameter int ADDR_WIDTH    = 5,
    parameter int DEPTH         = 32,
    parameter int AFULL_THRESH  = DEPTH - 2,
    parameter int AEMPTY_THRESH = 2,
    parameter int OUT_REG       = 0
) (
    input  wire logic                  clk,
    input  wire logic                  reset,
    kernel_bc_fifo_srl_param_if.slave  fifo
);

    localparam int                  c_idx_w  = $clog2(DEPTH);
    localparam logic [ADDR_WIDTH:0] c_one    = (ADDR_WIDTH + 1)'(1);
    localparam logic [ADDR_WIDTH:0] c_depth  = (ADDR_WIDTH + 1)'(DEPTH);
    localparam logic [ADDR_WIDTH:0] c_afull  = (ADDR_WIDTH + 1)'(AFULL_THRESH);
    localparam logic [ADDR_WIDTH:0] c_aempty = (ADDR_WIDTH + 1)'(AEMPTY_THRESH);

    logic [DATA_WIDTH-1:0] r_srl [DEPTH];
    logic [ADDR_WIDTH:0]   r_srl_cnt;
    logic [ADDR_WIDTH:0]   r_count;
    logic                  r_full_n;
    logic                  r_empty_n;
    logic                  r_afull_n;
    logic                  r_aempty_n;
    logic                  r_ovf;
    logic                  r_udf;

    logic                  w_wr;
    logic                  w_rd;
    logic                  w_wa;
    logic                  w_ra;
    logic                  w_dec;
    logic                  w_ov_nxt;
    logic                  w_empty_n_nxt;
    logic [c_idx_w-1:0]    w_head;
    logic [DATA_WIDTH-1:0] w_srl_head;
    logic [ADDR_WIDTH:0]   w_srl_cnt_nxt;
    logic [ADDR_WIDTH:0]   w_count_nxt;

    assign w_wr = fifo.if_write & fifo.if_write_ce;
    assign w_rd = fifo.if_read  & fifo.if_read_ce;
    assign w_wa = w_wr & r_full_n;
    assign w_ra = w_rd & r_empty_n;

    // Oldest word sits at index occupancy-1; clamp so an empty SRL still indexes in range.
    assign w_head     = (r_srl_cnt == '0) ? '0 : c_idx_w'(r_srl_cnt - c_one);
    assign w_srl_head = r_srl[w_head];

    assign w_srl_cnt_nxt = r_srl_cnt + {{ADDR_WIDTH{1'b0}}, w_wa}
                                     - {{ADDR_WIDTH{1'b0}}, w_dec};
    assign w_count_nxt   = w_srl_cnt_nxt + {{ADDR_WIDTH{1'b0}}, w_ov_nxt};

    generate
        if (OUT_REG != 0) begin : g_out_reg
            logic                  r_ov;
            logic [DATA_WIDTH-1:0] r_odata;
            logic                  w_load;

            // Refill the head register whenever it is free or being consumed.
            assign w_load        = (~r_ov | w_ra) & (r_srl_cnt != '0);
            assign w_dec         = w_load;
            assign w_ov_nxt      = w_load | (r_ov & ~w_ra);
            assign w_empty_n_nxt = w_ov_nxt;
            assign fifo.if_dout  = r_odata;

            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    r_ov    <= 1'b0;
                    r_odata <= '0;
                end else begin
                    r_ov <= w_ov_nxt;
                    if (w_load) begin
                        r_odata <= w_srl_head;
                    end
                end
            end
        end else begin : g_show_ahead
            assign w_dec         = w_ra;
            assign w_ov_nxt      = 1'b0;
            assign w_empty_n_nxt = (w_srl_cnt_nxt != '0);
            assign fifo.if_dout  = w_srl_head;
        end
    endgenerate

    // Storage is deliberately left unreset so it maps onto shift-register primitives.
    always_ff @(posedge clk) begin
        if (w_wa) begin
            r_srl[0] <= fifo.if_din;
            for (int i = 1; i < DEPTH; i++) begin
                r_srl[i] <= r_srl[i-1];
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_srl_cnt  <= '0;
            r_count    <= '0;
            r_full_n   <= 1'b1;
            r_empty_n  <= 1'b0;
            r_afull_n  <= 1'b1;
            r_aempty_n <= 1'b0;
            r_ovf      <= 1'b0;
            r_udf      <= 1'b0;
        end else begin
            r_srl_cnt  <= w_srl_cnt_nxt;
            r_count    <= w_count_nxt;
            r_full_n   <= (w_srl_cnt_nxt != c_depth);
            r_empty_n  <= w_empty_n_nxt;
            r_afull_n  <= (w_count_nxt < c_afull);
            r_aempty_n <= (w_count_nxt > c_aempty);
            r_ovf      <= r_ovf | (w_wr & ~r_full_n);
            r_udf      <= r_udf | (w_rd & ~r_empty_n);
        end
    end

    assign fifo.if_full_n         = r_full_n;
    assign fifo.if_empty_n        = r_empty_n;
    assign fifo.if_count          = r_count;
    assign fifo.if_almost_full_n  = r_afull_n;
    assign fifo.if_almost_empty_n = r_aempty_n;
    assign fifo.if_ovf            = r_ovf;
    assign fifo.if_udf            = r_udf;

endmodule
`default_nettype wire

// File: tb/tb_kernel_bc_fifo_srl_param.sv
`default_nettype none
// ============================================================================
// Module   : tb_kernel_bc_fifo_srl_param
// Brief    : Three FIFO configurations driven in lockstep against a queue model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_kernel_bc_fifo_srl_param;

    logic       clk   = 1'b0;
    logic       reset = 1'b0;
    logic       wr    = 1'b0;
    logic       wce   = 1'b1;
    logic       rd    = 1'b0;
    logic       rce   = 1'b1;
    logic [7:0] din   = 8'h00;

    always #5 clk = ~clk;

    kernel_bc_fifo_srl_param_if #(.DATA_WIDTH(8), .ADDR_WIDTH(5)) bus0 ();
    kernel_bc_fifo_srl_param_if #(.DATA_WIDTH(8), .ADDR_WIDTH(3)) bus1 ();
    kernel_bc_fifo_srl_param_if #(.DATA_WIDTH(8), .ADDR_WIDTH(2)) bus2 ();

    assign bus0.if_din = din;  assign bus0.if_write = wr;  assign bus0.if_write_ce = wce;
    assign bus0.if_read = rd;  assign bus0.if_read_ce = rce;
    assign bus1.if_din = din;  assign bus1.if_write = wr;  assign bus1.if_write_ce = wce;
    assign bus1.if_read = rd;  assign bus1.if_read_ce = rce;
    assign bus2.if_din = din;  assign bus2.if_write = wr;  assign bus2.if_write_ce = wce;
    assign bus2.if_read = rd;  assign bus2.if_read_ce = rce;

    kernel_bc_fifo_srl_param #(.DATA_WIDTH(8), .ADDR_WIDTH(5), .DEPTH(32),
        .AFULL_THRESH(30), .AEMPTY_THRESH(2), .OUT_REG(0))
        u_dut0 (.clk(clk), .reset(reset), .fifo(bus0));
    kernel_bc_fifo_srl_param #(.DATA_WIDTH(8), .ADDR_WIDTH(3), .DEPTH(7),
        .AFULL_THRESH(5), .AEMPTY_THRESH(2), .OUT_REG(0))
        u_dut1 (.clk(clk), .reset(reset), .fifo(bus1));
    kernel_bc_fifo_srl_param #(.DATA_WIDTH(8), .ADDR_WIDTH(2), .DEPTH(4),
        .AFULL_THRESH(3), .AEMPTY_THRESH(1), .OUT_REG(1))
        u_dut2 (.clk(clk), .reset(reset), .fifo(bus2));

    // Reference model: a plain FIFO of words plus the head-register valid bit.
    int         m_depth [3] = '{32, 7, 4};
    int         m_oreg  [3] = '{0, 0, 1};
    int         m_af    [3] = '{30, 5, 3};
    int         m_ae    [3] = '{2, 2, 1};
    logic [7:0] m_buf   [3][64];
    int         m_head  [3];
    int         m_cnt   [3];
    bit         m_ov    [3];
    bit         m_ovf   [3];
    bit         m_udf   [3];

    int n_cmp = 0;
    int n_err = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int m_srl(input int i);
        return m_cnt[i] - int'(m_ov[i]);
    endfunction

    function automatic bit m_full_n(input int i);
        return m_srl(i) != m_depth[i];
    endfunction

    function automatic bit m_empty_n(input int i);
        return (m_oreg[i] != 0) ? m_ov[i] : (m_cnt[i] != 0);
    endfunction

    task automatic m_clear();
        for (int i = 0; i < 3; i++) begin
            m_head[i] = 0; m_cnt[i] = 0; m_ov[i] = 0; m_ovf[i] = 0; m_udf[i] = 0;
        end
    endtask

    task automatic m_step(input int i);
        int srl     = m_srl(i);
        bit full_n  = m_full_n(i);
        bit empty_n = m_empty_n(i);
        bit wa      = wr && wce && full_n;
        bit ra      = rd && rce && empty_n;
        if (wr && wce && !full_n) m_ovf[i] = 1;
        if (rd && rce && !empty_n) m_udf[i] = 1;
        if (ra) begin
            m_head[i] = (m_head[i] + 1) % 64;
            m_cnt[i]--;
        end
        if (m_oreg[i] != 0)
            m_ov[i] = ((!m_ov[i] || ra) && srl > 0) ? 1'b1 : (ra ? 1'b0 : m_ov[i]);
        if (wa) begin
            m_buf[i][(m_head[i] + m_cnt[i]) % 64] = din;
            m_cnt[i]++;
        end
    endtask

    task automatic check_dut(input int i, input logic [31:0] cnt, input logic e, input logic f,
                             input logic af, input logic ae, input logic ov, input logic ud,
                             input logic [7:0] dout);
        check_eq($sformatf("d%0d_count", i),   cnt, m_cnt[i]);
        check_eq($sformatf("d%0d_empty_n", i), e,   m_empty_n(i));
        check_eq($sformatf("d%0d_full_n", i),  f,   m_full_n(i));
        check_eq($sformatf("d%0d_afull_n", i), af,  m_cnt[i] < m_af[i]);
        check_eq($sformatf("d%0d_aempty_n", i), ae, m_cnt[i] > m_ae[i]);
        check_eq($sformatf("d%0d_ovf", i),     ov,  m_ovf[i]);
        check_eq($sformatf("d%0d_udf", i),     ud,  m_udf[i]);
        if (m_empty_n(i))
            check_eq($sformatf("d%0d_dout", i), dout, m_buf[i][m_head[i]]);
    endtask

    task automatic check_all();
        check_dut(0, 32'(bus0.if_count), bus0.if_empty_n, bus0.if_full_n, bus0.if_almost_full_n,
                  bus0.if_almost_empty_n, bus0.if_ovf, bus0.if_udf, bus0.if_dout);
        check_dut(1, 32'(bus1.if_count), bus1.if_empty_n, bus1.if_full_n, bus1.if_almost_full_n,
                  bus1.if_almost_empty_n, bus1.if_ovf, bus1.if_udf, bus1.if_dout);
        check_dut(2, 32'(bus2.if_count), bus2.if_empty_n, bus2.if_full_n, bus2.if_almost_full_n,
                  bus2.if_almost_empty_n, bus2.if_ovf, bus2.if_udf, bus2.if_dout);
    endtask

    task automatic check_rst(input int i, input logic [31:0] cnt, input logic e, input logic f,
                             input logic af, input logic ae, input logic ov, input logic ud);
        check_eq($sformatf("rst%0d_count", i),    cnt, 0);
        check_eq($sformatf("rst%0d_empty_n", i),  e,   0);
        check_eq($sformatf("rst%0d_full_n", i),   f,   1);
        check_eq($sformatf("rst%0d_afull_n", i),  af,  1);
        check_eq($sformatf("rst%0d_aempty_n", i), ae,  0);
        check_eq($sformatf("rst%0d_ovf", i),      ov,  0);
        check_eq($sformatf("rst%0d_udf", i),      ud,  0);
    endtask

    // Called shortly after a rising edge; asserts reset mid-cycle and checks
    // the outputs react before any further clock edge.
    task automatic do_reset();
        #2 reset = 1'b1;
        #1;
        m_clear();
        check_rst(0, 32'(bus0.if_count), bus0.if_empty_n, bus0.if_full_n, bus0.if_almost_full_n,
                  bus0.if_almost_empty_n, bus0.if_ovf, bus0.if_udf);
        check_rst(1, 32'(bus1.if_count), bus1.if_empty_n, bus1.if_full_n, bus1.if_almost_full_n,
                  bus1.if_almost_empty_n, bus1.if_ovf, bus1.if_udf);
        check_rst(2, 32'(bus2.if_count), bus2.if_empty_n, bus2.if_full_n, bus2.if_almost_full_n,
                  bus2.if_almost_empty_n, bus2.if_ovf, bus2.if_udf);
        check_eq("rst2_dout", bus2.if_dout, 0);
        wr = 1'b0; rd = 1'b0; wce = 1'b1; rce = 1'b1;
        @(posedge clk);
        #1 reset = 1'b0;
    endtask

    task automatic drive(input logic w, input logic r, input logic [7:0] d);
        wr = w; rd = r; din = d; wce = 1'b1; rce = 1'b1;
    endtask

    task automatic tick();
        @(negedge clk);
        check_all();
        @(posedge clk);
        for (int i = 0; i < 3; i++) m_step(i);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        m_clear();
        do_reset();

        // Five writes then five reads, show-ahead ordering.
        for (int k = 0; k < 5; k++) begin
            drive(1'b1, 1'b0, 8'(8'h11 + k));
            tick();
        end
        check_eq("p1_count5", 32'(bus0.if_count), 5);
        for (int k = 0; k < 5; k++) begin
            drive(1'b0, 1'b1, 8'h00);
            check_eq("p1_dout", bus0.if_dout, 8'h11 + k);
            tick();
        end
        check_eq("p1_count0", 32'(bus0.if_count), 0);
        check_eq("p1_empty_n", bus0.if_empty_n, 0);

        // Fill the depth-7 instance past full.
        do_reset();
        for (int k = 1; k <= 8; k++) begin
            drive(1'b1, 1'b0, 8'(k));
            tick();
            if (k == 4) check_eq("p2_afull_n_w4", bus1.if_almost_full_n, 1);
            if (k == 5) check_eq("p2_afull_n_w5", bus1.if_almost_full_n, 0);
            if (k == 6) check_eq("p2_full_n_w6", bus1.if_full_n, 1);
            if (k == 7) check_eq("p2_full_n_w7", bus1.if_full_n, 0);
        end
        check_eq("p2_count", 32'(bus1.if_count), 7);
        check_eq("p2_ovf", bus1.if_ovf, 1);
        for (int k = 0; k < 9; k++) begin
            drive(1'b0, 1'b1, 8'h00);
            tick();
        end

        // Registered-output latency and capacity.
        do_reset();
        drive(1'b1, 1'b0, 8'hAB);
        tick();
        drive(1'b0, 1'b0, 8'h00);
        check_eq("p3_empty_n_d0_1cyc", bus0.if_empty_n, 1);
        check_eq("p3_empty_n_d2_1cyc", bus2.if_empty_n, 0);
        tick();
        check_eq("p3_empty_n_d2_2cyc", bus2.if_empty_n, 1);
        check_eq("p3_dout_d2", bus2.if_dout, 8'hAB);
        for (int k = 0; k < 5; k++) begin
            drive(1'b1, 1'b0, 8'($urandom));
            tick();
        end
        check_eq("p3_count_cap", 32'(bus2.if_count), 5);
        check_eq("p3_ovf_d2", bus2.if_ovf, 1);
        for (int k = 0; k < 7; k++) begin
            drive(1'b0, 1'b1, 8'h00);
            tick();
        end

        // Read while empty, with and without the read clock-enable.
        do_reset();
        wr = 1'b0; rd = 1'b1; rce = 1'b0;
        tick();
        check_eq("p4_udf_ce0", bus0.if_udf, 0);
        rce = 1'b1;
        tick();
        check_eq("p4_udf_ce1", bus0.if_udf, 1);
        check_eq("p4_count", 32'(bus0.if_count), 0);
        check_eq("p4_udf_d2", bus2.if_udf, 1);

        // Sustained simultaneous read and write at occupancy 3.
        do_reset();
        for (int k = 0; k < 3; k++) begin
            drive(1'b1, 1'b0, 8'(k));
            tick();
        end
        for (int k = 0; k < 100; k++) begin
            drive(1'b1, 1'b1, 8'(k + 3));
            tick();
            check_eq("p5_count", 32'(bus0.if_count), 3);
        end

        // Randomised traffic with alternating fill/drain bias.
        do_reset();
        for (int c = 0; c < 600; c++) begin
            int wp;
            wp  = ((c / 100) % 2 == 0) ? 80 : 20;
            wr  = ($urandom_range(0, 99) < wp);
            rd  = ($urandom_range(0, 99) < (100 - wp));
            wce = ($urandom_range(0, 7) != 0);
            rce = ($urandom_range(0, 7) != 0);
            din = 8'($urandom);
            tick();
        end

        // Reset mid-burst at occupancy 4, then a fresh word must come out first.
        do_reset();
        for (int k = 0; k < 4; k++) begin
            drive(1'b1, 1'b0, 8'(8'h21 + k));
            tick();
        end
        check_eq("p7_count4", 32'(bus0.if_count), 4);
        drive(1'b1, 1'b0, 8'h99);
        do_reset();
        drive(1'b1, 1'b0, 8'h5A);
        tick();
        drive(1'b0, 1'b0, 8'h00);
        tick();
        check_eq("p7_dout_d0", bus0.if_dout, 8'h5A);
        check_eq("p7_dout_d2", bus2.if_dout, 8'h5A);
        check_eq("p7_empty_n_d2", bus2.if_empty_n, 1);
        drive(1'b0, 1'b1, 8'h00);
        tick();
        drive(1'b0, 1'b0, 8'h00);
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/kernel_bc_fifo_srl_param.md
# kernel_bc_fifo_srl_param

Parametrised shift-register FIFO for streaming between kernel_bc dataflow processes. It is the next generation of the fixed w32/d32 SRL FIFO:
- width and depth are free parameters, and depth need not be a power of two;
- occupancy count, programmable almost-full/almost-empty flags and a sticky overflow/underflow status are added;
- an optional registered output stage is added for timing closure on long routes.

The handshake is unchanged: valid/ready pairs with read/write clock-enables.

## Interface
Parameters:
- DATA_WIDTH, 32, word width in bits (1..1024)
- ADDR_WIDTH, 5, SRL address width; requires 2^ADDR_WIDTH >= DEPTH
- DEPTH, 32, SRL storage words (2..2^ADDR_WIDTH, any integer)
- AFULL_THRESH, DEPTH-2, if_almost_full_n low when if_count >= AFULL_THRESH
- AEMPTY_THRESH, 2, if_almost_empty_n low when if_count <= AEMPTY_THRESH
- OUT_REG, 0, 0 = show-ahead straight from SRL; 1 = registered head word (capacity DEPTH+1)

Ports (one clock; reset is asynchronous and active-high):
- clk  in  1  clock, all state on rising edge
- reset  in  1  asynchronous active-high reset
- if_din  in  DATA_WIDTH  write data
- if_write  in  1  write request
- if_write_ce  in  1  write clock-enable; effective write request wr = if_write & if_write_ce
- if_full_n  out  1  1 = can accept a write
- if_dout  out  DATA_WIDTH  head word, valid while if_empty_n=1
- if_read  in  1  read request
- if_read_ce  in  1  read clock-enable; effective read request rd = if_read & if_read_ce
- if_empty_n  out  1  1 = if_dout valid
- if_count  out  ADDR_WIDTH+1  words held (SRL plus output register)
- if_almost_full_n  out  1  registered threshold flag
- if_almost_empty_n  out  1  registered threshold flag
- if_ovf  out  1  sticky: wr seen while if_full_n=0
- if_udf  out  1  sticky: rd seen while if_empty_n=0

## Operation
- Accepted write: wa = wr & if_full_n. Accepted read: ra = rd & if_empty_n. Rejected requests change nothing except setting the sticky flags.
- SRL: on wa, shift all entries up by one and load if_din at index 0. Head index = SRL occupancy - 1.
- OUT_REG=0:
  - if_dout = SRL[head]; head clamps to 0 when the SRL is empty.
  - Pointer update: wa only -> +1; ra only -> -1; wa and ra together -> unchanged.
- OUT_REG=1:
  - An output register (ov, odata) forms the head.
  - When ov=0 or ra, and the SRL is non-empty, load odata <= SRL[head], set ov=1 and decrement the SRL count (net of a simultaneous wa).
  - On ra with an empty SRL, clear ov.
  - A write into a completely empty FIFO lands in the SRL first; it is never bypassed into the output register.
- if_count = SRL count + ov. Capacity is CAP = DEPTH + OUT_REG.
- Flags (all registered, computed from the next count): if_full_n = (count != CAP)... specifically:
  - if_full_n = (SRL count != DEPTH)
  - if_empty_n = (OUT_REG ? ov : SRL count != 0)
  - if_almost_full_n = (count < AFULL_THRESH)
  - if_almost_empty_n = (count > AEMPTY_THRESH)
- Width rule: all count arithmetic is ADDR_WIDTH+1 bits. The count never wraps, because wa is blocked at full and ra is blocked at empty.

## Timing
- Reset (async assert, synchronous-safe release) forces:
  - if_count=0, if_empty_n=0, if_full_n=1, if_almost_full_n=1, if_almost_empty_n=0
  - if_ovf=0, if_udf=0, ov=0, odata=0
  - SRL contents are not reset; if_dout is don't-care while if_empty_n=0 (OUT_REG=1: if_dout=0).
- Reset mid-operation discards all data. Outputs take their reset values immediately, not at the next edge.
- Write-to-read latency: with OUT_REG=0, if_empty_n rises on the edge that accepts the write (1 cycle). With OUT_REG=1 it rises one edge later (2 cycles).
- Full is decided on the SRL only: if_full_n falls on the edge that makes the SRL count reach DEPTH.
- Read when full plus write in the same cycle: the read is accepted, the write is rejected, and if_ovf sets.
- Read when empty plus write in the same cycle: the write is accepted, the read is rejected, and if_udf sets.
- Throughput is one word per cycle in each direction, including sustained simultaneous read and write at any fill level strictly between empty and full.

## Test plan
- Reset, then 5 writes (0x11..0x15), then 5 reads; DEPTH=32, OUT_REG=0 -> if_dout sequence 0x11..0x15. if_count goes 0→5→0. if_empty_n is low after the final read.
- Fill DEPTH=7 (non-power-of-two), AFULL_THRESH=5 -> if_almost_full_n falls after write 5 and if_full_n after write 7. An eighth write is dropped: if_count stays 7 and if_ovf=1.
- Simultaneous rd/wr for 100 cycles at count=3 with incrementing data -> if_count constant at 3, output data in order with no gaps.
- OUT_REG=1, DEPTH=4: single write of 0xAB -> if_empty_n high 2 cycles after the write, if_dout=0xAB. Then write 5 words -> if_count=5 (CAP). Then drain all -> data in order.
- Read while empty with if_read_ce=1 -> if_udf=1, if_count stays 0. With if_read_ce=0 the same pulse leaves if_udf=0.
- Assert reset asynchronously mid-burst at count=4 -> all outputs at reset values before the next clk edge. After release, the first written word is the first read.
